// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared types and constants for the banked-memory arbiter
package rv32i_types;

  localparam int BMEM_BEATS  = 4;
  localparam int BMEM_BEAT_W = 64;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_I_RD,
    REQ_D_RD,
    REQ_D_WR
  } bmem_req_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_WRITE
  } arb_state_t;

endpackage

// File: rtl/bmem_burst_deser.sv
// rtl/bmem_burst_deser.sv - per-port read tracker that assembles a returning burst into a line
module bmem_burst_deser
  import rv32i_types::*;
#(
  parameter int ADDR_W = 32,
  parameter int BEAT_W = BMEM_BEAT_W,
  parameter int BEATS  = BMEM_BEATS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    issue,
  input  logic [ADDR_W-1:0]       issue_addr,
  input  logic                    rvalid,
  input  logic [ADDR_W-1:0]       raddr,
  input  logic [BEAT_W-1:0]       rdata,
  output logic                    valid,
  output logic [ADDR_W-1:0]       addr,
  output logic                    hit,
  output logic [BEAT_W*BEATS-1:0] line,
  output logic                    resp
);

  localparam int CNT_W = $clog2(BEATS);

  logic [CNT_W-1:0] cnt;

  // A beat belongs to this port only while its tracker waits on that address.
  assign hit = rvalid && valid && (raddr == addr);

  // Tracker state: armed by an accepted read, filled beat by beat, retired with a one-cycle resp.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      addr  <= '0;
      cnt   <= '0;
      line  <= '0;
      resp  <= 1'b0;
    end else begin
      resp <= 1'b0;
      if (issue) begin
        valid <= 1'b1;
        addr  <= issue_addr;
        cnt   <= '0;
      end else if (hit) begin
        line[cnt*BEAT_W +: BEAT_W] <= rdata;
        cnt <= cnt + 1'b1;
        if (cnt == CNT_W'(BEATS - 1)) begin
          valid <= 1'b0;
          resp  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bmem_arbiter.sv
// rtl/bmem_arbiter.sv - shares the banked-memory port between icache and dcache
module bmem_arbiter
  import rv32i_types::*;
#(
  parameter int ADDR_W = 32,
  parameter int BEAT_W = BMEM_BEAT_W,
  parameter int BEATS  = BMEM_BEATS,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_read,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [ADDR_W-1:0] bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic              bmem_ready,
  input  logic [ADDR_W-1:0] bmem_raddr,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_rvalid
);

  localparam int CNT_W = $clog2(BEATS);
  localparam int QW    = $clog2(BEATS + 1);

  arb_state_t       state, state_next;
  bmem_req_t        sel, hold_req, d_kind;
  logic             rr;
  logic             hold;
  logic [CNT_W-1:0] wcnt;
  logic             wr_resp, wr_done;
  logic             done_i, done_d;
  logic [QW-1:0]    quiet;
  logic             accept;
  logic             i_issue, d_issue;
  logic             i_trk_valid, d_trk_valid;
  logic [ADDR_W-1:0] i_trk_addr, d_trk_addr;
  logic             i_hit, d_hit;
  logic             d_rd_resp;
  logic             i_elig, d_elig;

  bmem_burst_deser #(.ADDR_W(ADDR_W), .BEAT_W(BEAT_W), .BEATS(BEATS)) u_i_deser (
    .clk(clk), .rst(rst), .issue(i_issue), .issue_addr(i_addr),
    .rvalid(bmem_rvalid), .raddr(bmem_raddr), .rdata(bmem_rdata),
    .valid(i_trk_valid), .addr(i_trk_addr), .hit(i_hit), .line(i_rdata), .resp(i_resp)
  );

  bmem_burst_deser #(.ADDR_W(ADDR_W), .BEAT_W(BEAT_W), .BEATS(BEATS)) u_d_deser (
    .clk(clk), .rst(rst), .issue(d_issue), .issue_addr(d_addr),
    .rvalid(bmem_rvalid), .raddr(bmem_raddr), .rdata(bmem_rdata),
    .valid(d_trk_valid), .addr(d_trk_addr), .hit(d_hit), .line(d_rdata), .resp(d_rd_resp)
  );

  assign d_resp = d_rd_resp | wr_resp;
  assign d_kind = d_write ? REQ_D_WR : REQ_D_RD;

  // A port competes only once per request, never with its own read in flight,
  // and never for a line the other port is currently reading.
  assign i_elig = i_read && !i_trk_valid && !done_i && !i_resp &&
                  !(d_trk_valid && (d_trk_addr == i_addr));
  assign d_elig = (d_write || (d_read && !d_trk_valid &&
                  !(i_trk_valid && (i_trk_addr == d_addr)))) && !done_d && !d_resp;

  // Command selection, bmem command drive and next-state.
  always_comb begin
    state_next = state;
    sel        = REQ_NONE;
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    bmem_addr  = '0;
    bmem_wdata = '0;
    i_issue    = 1'b0;
    d_issue    = 1'b0;
    accept     = 1'b0;
    wr_done    = 1'b0;
    if (!rst) begin
      case (state)
        ARB_IDLE: begin
          if (hold)                sel = hold_req;
          else if (i_elig && d_elig) sel = rr ? d_kind : REQ_I_RD;
          else if (i_elig)         sel = REQ_I_RD;
          else if (d_elig)         sel = d_kind;
          case (sel)
            REQ_I_RD: begin
              bmem_read = 1'b1;
              bmem_addr = i_addr;
              i_issue   = bmem_ready;
              accept    = bmem_ready;
            end
            REQ_D_RD: begin
              bmem_read = 1'b1;
              bmem_addr = d_addr;
              d_issue   = bmem_ready;
              accept    = bmem_ready;
            end
            REQ_D_WR: begin
              state_next = ARB_WRITE;
              accept     = 1'b1;
            end
            default: ;
          endcase
        end
        ARB_WRITE: begin
          bmem_write = 1'b1;
          bmem_addr  = d_addr;
          bmem_wdata = d_wdata[wcnt*BEAT_W +: BEAT_W];
          if (bmem_ready && (wcnt == CNT_W'(BEATS - 1))) begin
            wr_done    = 1'b1;
            state_next = ARB_IDLE;
          end
        end
        default: state_next = ARB_IDLE;
      endcase
    end
  end

  // FSM, round-robin pointer, held command, write beat counter and done flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB_IDLE;
      rr       <= 1'b0;
      hold     <= 1'b0;
      hold_req <= REQ_NONE;
      wcnt     <= '0;
      wr_resp  <= 1'b0;
      done_i   <= 1'b0;
      done_d   <= 1'b0;
      quiet    <= QW'(BEATS);
    end else begin
      state    <= state_next;
      if (accept) rr <= (sel == REQ_I_RD);
      hold     <= ((sel == REQ_I_RD) || (sel == REQ_D_RD)) && !bmem_ready;
      hold_req <= sel;
      if (wr_done)                                   wcnt <= '0;
      else if ((state == ARB_WRITE) && bmem_ready)   wcnt <= wcnt + 1'b1;
      wr_resp  <= wr_done;
      done_i   <= i_read && (done_i || i_resp);
      done_d   <= (d_read || d_write) && (done_d || d_resp);
      if (quiet != '0) quiet <= quiet - 1'b1;
    end
  end

  // Every returning beat must belong to a waiting tracker, except stragglers right after reset.
  stray_beat_a: assert property (@(posedge clk) disable iff (rst)
    (bmem_rvalid && (quiet == '0)) |-> (i_hit || d_hit));

endmodule

// File: tb/tb_bmem_arbiter.sv
// tb/tb_bmem_arbiter.sv - directed self-checking bench for bmem_arbiter
module tb_bmem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  i_addr;
  logic         i_read;
  logic [255:0] i_rdata;
  logic         i_resp;
  logic [31:0]  d_addr;
  logic         d_read;
  logic         d_write;
  logic [255:0] d_wdata;
  logic [255:0] d_rdata;
  logic         d_resp;
  logic [31:0]  bmem_addr;
  logic         bmem_read;
  logic         bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready;
  logic [31:0]  bmem_raddr;
  logic [63:0]  bmem_rdata;
  logic         bmem_rvalid;

  int tests = 0;
  int fails = 0;
  int rd_pulses = 0;
  int base;

  localparam logic [255:0] LINE_A = {64'hA3A3_0000_0000_0003, 64'hA2A2_0000_0000_0002,
                                     64'hA1A1_0000_0000_0001, 64'hA0A0_0000_0000_0000};
  localparam logic [255:0] LINE_B = {64'hB3B3_1111_2222_3333, 64'hB2B2_1111_2222_3333,
                                     64'hB1B1_1111_2222_3333, 64'hB0B0_1111_2222_3333};
  localparam logic [255:0] LINE_C = {64'hC3C3_4444_5555_6666, 64'hC2C2_4444_5555_6666,
                                     64'hC1C1_4444_5555_6666, 64'hC0C0_4444_5555_6666};
  localparam logic [255:0] LINE_W = {64'h5757_0303_0303_0303, 64'h5757_0202_0202_0202,
                                     64'h5757_0101_0101_0101, 64'h5757_0000_0000_0000};
  localparam logic [255:0] LINE_V = {64'h7676_DDDD_0000_0003, 64'h7676_DDDD_0000_0002,
                                     64'h7676_DDDD_0000_0001, 64'h7676_DDDD_0000_0000};

  bmem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bmem_read && bmem_ready) rd_pulses++;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    bmem_rvalid = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic burst(input logic [31:0] a, input logic [255:0] l);
    for (int k = 0; k < 4; k++) begin
      bmem_rvalid = 1'b1;
      bmem_raddr  = a;
      bmem_rdata  = l[k*64 +: 64];
      step();
    end
    bmem_rvalid = 1'b0;
  endtask

  initial begin
    i_addr = '0; d_addr = '0; d_wdata = '0;
    bmem_ready = 1'b1; bmem_raddr = '0; bmem_rdata = '0;
    do_reset();
    rst = 1'b1;
    settle();
    check("reset_bmem_read", bmem_read, 0);
    check("reset_bmem_write", bmem_write, 0);
    check("reset_resp", {i_resp, d_resp}, 0);
    check("reset_i_rdata", i_rdata, 0);
    check("reset_d_rdata", d_rdata, 0);
    step();
    rst = 1'b0;

    // 1: lone I read
    i_addr = 32'h0000_1000; i_read = 1'b1; bmem_ready = 1'b1;
    settle();
    check("t1_cmd_read", bmem_read, 1);
    check("t1_cmd_addr", bmem_addr, 32'h0000_1000);
    step();
    settle();
    check("t1_single_cmd", bmem_read, 0);
    burst(32'h0000_1000, LINE_A);
    i_read = 1'b0;
    settle();
    check("t1_i_resp", i_resp, 1);
    check("t1_i_rdata", i_rdata, LINE_A);
    step();
    settle();
    check("t1_i_resp_pulse", i_resp, 0);

    // 2: simultaneous I and D reads, rr favours I, returned D first
    do_reset();
    i_addr = 32'h0000_4000; d_addr = 32'h0000_5000;
    i_read = 1'b1; d_read = 1'b1;
    settle();
    check("t2_first_cmd", {bmem_read, bmem_addr}, {1'b1, 32'h0000_4000});
    step();
    settle();
    check("t2_second_cmd", {bmem_read, bmem_addr}, {1'b1, 32'h0000_5000});
    step();
    settle();
    check("t2_no_more_cmd", bmem_read, 0);
    burst(32'h0000_5000, LINE_B);
    d_read = 1'b0;
    settle();
    check("t2_d_resp_first", {i_resp, d_resp}, 2'b01);
    check("t2_d_rdata", d_rdata, LINE_B);
    burst(32'h0000_4000, LINE_C);
    i_read = 1'b0;
    settle();
    check("t2_i_resp_second", {i_resp, d_resp}, 2'b10);
    check("t2_i_rdata", i_rdata, LINE_C);

    // 3: D write with a 3-cycle stall on the second beat
    do_reset();
    d_addr = 32'h0000_2000; d_wdata = LINE_W; d_write = 1'b1;
    settle();
    check("t3_idle_no_write", bmem_write, 0);
    step();
    settle();
    check("t3_beat0", {bmem_write, bmem_addr, bmem_wdata}, {1'b1, 32'h0000_2000, 64'h5757_0000_0000_0000});
    step();
    bmem_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      settle();
      check("t3_stall_hold", {bmem_write, bmem_wdata}, {1'b1, 64'h5757_0101_0101_0101});
      step();
    end
    bmem_ready = 1'b1;
    settle();
    check("t3_beat1", {bmem_write, bmem_wdata}, {1'b1, 64'h5757_0101_0101_0101});
    step();
    settle();
    check("t3_beat2", {bmem_write, bmem_wdata}, {1'b1, 64'h5757_0202_0202_0202});
    step();
    settle();
    check("t3_beat3", {bmem_write, bmem_wdata}, {1'b1, 64'h5757_0303_0303_0303});
    check("t3_no_early_resp", d_resp, 0);
    step();
    d_write = 1'b0;
    settle();
    check("t3_d_resp", {d_resp, bmem_write}, 2'b10);
    step();
    settle();
    check("t3_d_resp_pulse", d_resp, 0);

    // 4: I burst returns while a D write is streaming out
    do_reset();
    i_addr = 32'h0000_6000; i_read = 1'b1;
    d_addr = 32'h0000_7000; d_wdata = LINE_V; d_write = 1'b1;
    settle();
    check("t4_i_cmd", {bmem_read, bmem_addr}, {1'b1, 32'h0000_6000});
    step();
    settle();
    check("t4_write_select", {bmem_read, bmem_write}, 2'b00);
    for (int k = 0; k < 4; k++) begin
      step();
      bmem_rvalid = 1'b1;
      bmem_raddr  = 32'h0000_6000;
      bmem_rdata  = LINE_A[k*64 +: 64];
      settle();
      check("t4_wbeat", {bmem_write, bmem_wdata}, {1'b1, LINE_V[k*64 +: 64]});
    end
    step();
    bmem_rvalid = 1'b0; i_read = 1'b0; d_write = 1'b0;
    settle();
    check("t4_both_resp", {i_resp, d_resp, bmem_write}, 3'b110);
    check("t4_i_rdata", i_rdata, LINE_A);
    step();
    settle();
    check("t4_resp_pulse", {i_resp, d_resp}, 2'b00);

    // 5: both ports read the same line
    do_reset();
    base = rd_pulses;
    i_addr = 32'h0000_3000; d_addr = 32'h0000_3000;
    i_read = 1'b1; d_read = 1'b1;
    settle();
    check("t5_i_cmd", {bmem_read, bmem_addr}, {1'b1, 32'h0000_3000});
    step();
    settle();
    check("t5_d_blocked", bmem_read, 0);
    burst(32'h0000_3000, LINE_B);
    i_read = 1'b0;
    settle();
    check("t5_i_resp", {i_resp, i_rdata}, {1'b1, LINE_B});
    check("t5_d_cmd_after", {bmem_read, bmem_addr}, {1'b1, 32'h0000_3000});
    step();
    settle();
    check("t5_d_single_cmd", bmem_read, 0);
    burst(32'h0000_3000, LINE_C);
    d_read = 1'b0;
    settle();
    check("t5_d_resp", {d_resp, d_rdata}, {1'b1, LINE_C});
    step();
    check("t5_read_pulses", rd_pulses - base, 2);

    // 6: reset during WRITE beat 2, then a stray burst
    do_reset();
    d_addr = 32'h0000_8000; d_wdata = LINE_W; d_write = 1'b1;
    step();
    step();
    step();
    settle();
    check("t6_beat2", {bmem_write, bmem_wdata}, {1'b1, 64'h5757_0202_0202_0202});
    rst = 1'b1;
    step();
    d_write = 1'b0;
    settle();
    check("t6_in_reset", {bmem_write, d_resp}, 2'b00);
    step();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bmem_rvalid = 1'b1;
      bmem_raddr  = 32'h0000_8000;
      bmem_rdata  = LINE_A[k*64 +: 64];
      settle();
      check("t6_quiet", {bmem_write, bmem_read, i_resp, d_resp}, 4'b0000);
      step();
    end
    bmem_rvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      check("t6_after", {bmem_write, i_resp, d_resp}, 3'b000);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
